sram_page_tracker: RTL

Parametrised page-bookkeeping block for one shared packet SRAM. It owns the free-page list and the per-page ECC side storage, plus per-port page counters and a free-space counter. It adds an init sequencer, an alloc grant handshake, per-port quota flags and sticky error flags. It sits beside the SRAM, between the write-port arbiter (alloc) and the read scheduler (free).

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_page_tracker_free_list.sv | 92 +++++++++
 rtl/sram_page_tracker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared constants, types and FSM encoding for the packet SRAM
// page tracker and its free-page list.
package sram_pkg;

    localparam int NUM_PORTS_DEF  = 16;
    localparam int PAGE_DEPTH_DEF = 2048;
    localparam int ECC_W_DEF      = 8;
    localparam int ADDR_W_DEF     = $clog2(PAGE_DEPTH_DEF);
    localparam int CNT_W_DEF      = $clog2(PAGE_DEPTH_DEF + 1);

    typedef logic [ADDR_W_DEF-1:0] page_addr_t;
    typedef logic [CNT_W_DEF-1:0]  page_cnt_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/sram_page_tracker_free_list.sv
// Circular free-page list: loads 0..PAGE_DEPTH-1 after reset, then pops
// at head (show-ahead) and pushes released pages at tail.
module page_free_list
    import sram_pkg::*;
#(
    parameter int PAGE_DEPTH = 2048,
    parameter int ADDR_W     = $clog2(PAGE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pop,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] head_addr,
    output logic              init_done,
    output logic              init_last,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = ADDR_W + 1;

    logic [ADDR_W-1:0] list_q [PAGE_DEPTH];
    fsm_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_data;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        head_d    = head_q;
        tail_d    = tail_q;
        wr_en     = 1'b0;
        wr_addr   = tail_q[ADDR_W-1:0];
        wr_data   = push_addr;
        init_last = 1'b0;
        unique case (state_q)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = idx_q;
                idx_d   = idx_q + 1'b1;
                if (idx_q == ADDR_W'(PAGE_DEPTH - 1)) begin
                    init_last = 1'b1;
                    state_d   = RUN;
                    // extra pointer bit set: list starts out full
                    tail_d    = PTR_W'(PAGE_DEPTH);
                end
            end
            RUN: begin
                if (pop) begin
                    head_d = head_q + 1'b1;
                end
                if (push) begin
                    wr_en  = 1'b1;
                    tail_d = tail_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            list_q[wr_addr] <= wr_data;
        end
    end

    assign head_addr = list_q[head_q[ADDR_W-1:0]];
    assign init_done = (state_q == RUN);
    assign empty     = (head_q == tail_q);
    assign full      = ((tail_q - head_q) == PTR_W'(PAGE_DEPTH));

endmodule

// File: rtl/sram_page_tracker.sv
// Page bookkeeping for the shared packet SRAM: free list, per-page ECC
// side store, per-port page counters, quota flags and sticky errors.
module sram_page_tracker
    import sram_pkg::*;
#(
    parameter int NUM_PORTS  = 16,
    parameter int PAGE_DEPTH = 2048,
    parameter int ADDR_W     = $clog2(PAGE_DEPTH),
    parameter int ECC_W      = 8,
    parameter int CNT_W      = $clog2(PAGE_DEPTH + 1),
    parameter int PORT_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_done,
    input  logic                 ecc_wr_en,
    input  logic [ADDR_W-1:0]    ecc_wr_addr,
    input  logic [ECC_W-1:0]     ecc_din,
    input  logic                 ecc_rd_en,
    input  logic [ADDR_W-1:0]    ecc_rd_addr,
    output logic [ECC_W-1:0]     ecc_dout,
    input  logic                 alloc_req,
    input  logic [PORT_W-1:0]    alloc_port,
    output logic                 alloc_gnt,
    output logic [ADDR_W-1:0]    alloc_addr,
    input  logic                 free_req,
    input  logic [PORT_W-1:0]    free_port,
    input  logic [ADDR_W-1:0]    free_addr,
    input  logic [PORT_W-1:0]    query_port,
    output logic [CNT_W-1:0]     page_amount,
    output logic [CNT_W-1:0]     free_space,
    input  logic [CNT_W-1:0]     quota,
    output logic [NUM_PORTS-1:0] over_quota,
    output logic                 err_overflow,
    output logic                 err_underflow
);

    localparam int SUM_W = CNT_W + PORT_W + 1;

    logic [CNT_W-1:0] cnt_q [NUM_PORTS];
    logic [CNT_W-1:0] cnt_d [NUM_PORTS];
    logic [CNT_W-1:0] free_space_q, free_space_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;
    logic [ECC_W-1:0] ecc_mem_q [PAGE_DEPTH];
    logic [ECC_W-1:0] ecc_dout_q, ecc_dout_d;
    logic             lst_full, lst_empty, init_last;
    logic             free_ok, free_rej;
    logic [SUM_W-1:0] cnt_sum;

    page_free_list #(
        .PAGE_DEPTH (PAGE_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_list (
        .clk       (clk),
        .rst       (rst),
        .pop       (alloc_gnt),
        .push      (free_ok),
        .push_addr (free_addr),
        .head_addr (alloc_addr),
        .init_done (init_done),
        .init_last (init_last),
        .full      (lst_full),
        .empty     (lst_empty)
    );

    always_comb begin
        alloc_gnt = alloc_req & init_done & ~lst_empty;
        free_ok   = free_req & init_done & ~lst_full
                  & (cnt_q[free_port] != '0);
        free_rej  = free_req & ~free_ok;
        cnt_d     = cnt_q;
        if (alloc_gnt) begin
            cnt_d[alloc_port] = cnt_d[alloc_port] + CNT_W'(1);
        end
        if (free_ok) begin
            cnt_d[free_port] = cnt_d[free_port] - CNT_W'(1);
        end
        free_space_d = free_space_q;
        if (init_last) begin
            free_space_d = CNT_W'(PAGE_DEPTH);
        end else if (alloc_gnt && !free_ok) begin
            free_space_d = free_space_q - CNT_W'(1);
        end else if (free_ok && !alloc_gnt) begin
            free_space_d = free_space_q + CNT_W'(1);
        end
        err_ovf_d  = err_ovf_q | (free_rej & (~init_done | lst_full));
        err_unf_d  = err_unf_q | (free_rej & init_done & ~lst_full);
        ecc_dout_d = ecc_rd_en ? ecc_mem_q[ecc_rd_addr] : ecc_dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
            free_space_q <= '0;
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
            ecc_dout_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            free_space_q <= free_space_d;
            err_ovf_q    <= err_ovf_d;
            err_unf_q    <= err_unf_d;
            ecc_dout_q   <= ecc_dout_d;
        end
    end

    // ECC contents survive reset; only writes are blocked while in it
    always_ff @(posedge clk) begin
        if (!rst && ecc_wr_en) begin
            ecc_mem_q[ecc_wr_addr] <= ecc_din;
        end
    end

    always_comb begin
        cnt_sum = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            over_quota[p] = (cnt_q[p] >= quota);
            cnt_sum       = cnt_sum + SUM_W'(cnt_q[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && init_done) begin
            assert (cnt_sum + SUM_W'(free_space_q) == SUM_W'(PAGE_DEPTH));
        end
    end

    assign page_amount   = cnt_q[query_port];
    assign free_space    = free_space_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
    assign ecc_dout      = ecc_dout_q;

endmodule
